// File: rtl/fifo_stream_drain_pkg.sv
// Shared types and sizing for the FIFO-to-AXI4-Stream drain block.
// Optional statistics are enabled by FIFO_STREAM_DRAIN_STATS_EN.
package fifo_stream_drain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int BEAT_CNT_W = 9;
    localparam int OBUF_DEPTH = 2;
    localparam int OCC_W      = $clog2(OBUF_DEPTH + 1);

endpackage

// File: rtl/fifo_stream_drain_obuf.sv
// Two-entry {data, last} skid buffer feeding the stream outputs.
// Head entry is registered, so outputs carry no input-to-output path.
module fifo_stream_drain_obuf
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [OCC_W-1:0]      occ
);

    logic [OBUF_DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [OBUF_DEPTH-1:0]                 last_q;
    logic                                  wr_ptr;
    logic                                  rd_ptr;

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            last_q <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a registered-output FIFO into fixed-length AXI4-Stream packets.
// Define FIFO_STREAM_DRAIN_STATS_EN to add beat/packet counters.
module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  busy
`ifdef FIFO_STREAM_DRAIN_STATS_EN
    ,
    output logic [31:0]           beat_total,
    output logic [31:0]           pkt_total
`endif
);

    state_t                state_q;
    state_t                state_d;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  inflight;
    logic                  inflight_last;
    logic [OCC_W-1:0]      occ;
    logic                  pop;
    logic                  rd_last;
    logic                  may_read;
    logic [2:0]            fill;

    assign pop  = m_tvalid & m_tready;
    // Slots already claimed once this cycle's pop is accounted for.
    assign fill = 3'(occ) + 3'(inflight) - 3'(pop);

    always_comb begin
        may_read = 1'b0;
        unique case (1'b1)
            state_q == BURST: may_read = 1'b1;
            state_q == IDLE:  may_read = enable;
            default:          may_read = 1'b0;
        endcase
    end

    assign fifo_rd = !fifo_empty && may_read && (fill < 3'(OBUF_DEPTH));
    assign rd_last = fifo_rd &&
                     (beat_cnt == BEAT_CNT_W'(BURST_LEN - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = rd_last ? IDLE : BURST;
                end
            end
            BURST: begin
                if (rd_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_cnt      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflight      <= fifo_rd;
            inflight_last <= rd_last;
            if (fifo_rd) begin
                beat_cnt <= rd_last ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    fifo_stream_drain_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_data(fifo_data),
        .push_last(inflight_last),
        .pop      (pop),
        .head_data(m_tdata),
        .head_last(m_tlast),
        .occ      (occ)
    );

    assign m_tvalid = (occ != '0);
    assign busy     = (state_q == BURST) | (occ != '0) | inflight;

`ifdef FIFO_STREAM_DRAIN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_total <= '0;
            pkt_total  <= '0;
        end else if (pop) begin
            beat_total <= beat_total + 32'd1;
            if (m_tlast) begin
                pkt_total <= pkt_total + 32'd1;
            end
        end
    end
`endif

endmodule
